// File: rtl/ub_pkg.sv
// ub_pkg: shared widths, address-field helpers and word type for the unified-buffer arbiter.
// Byte addresses are {word, bank, byte}; bulk addresses are {word, bank}.
package ub_pkg;
    localparam int UB_SA_LENGTH = 256;
    typedef logic [UB_SA_LENGTH-1:0][7:0] ub_word_t;
    function automatic int bw_f(input int aw, input int nb);
        return aw + $clog2(nb);
    endfunction
    function automatic int yw_f(input int aw, input int nb, input int sa);
        return bw_f(aw, nb) + $clog2(sa);
    endfunction
    function automatic int word_of(input int bulk, input int nb);
        return bulk >> $clog2(nb);
    endfunction
    function automatic int bank_of(input int bulk, input int nb);
        return bulk % nb;
    endfunction
    function automatic int byte_of(input int baddr, input int sa);
        return baddr % sa;
    endfunction
    function automatic int bulk_of(input int baddr, input int sa);
        return baddr >> $clog2(sa);
    endfunction
endpackage

// File: rtl/ub_arb_if.sv
// ub_arb_if: requester handshakes (host, accumulator, feeder) and the buffer-side command/data bus.
interface ub_arb_if #(
    parameter int SA_LENGTH  = 256,
    parameter int ADDR_WIDTH = 10,
    parameter int NO_BANKS   = 8
);
    import ub_pkg::*;
    localparam int BW = bw_f(ADDR_WIDTH, NO_BANKS);
    localparam int YW = yw_f(ADDR_WIDTH, NO_BANKS, SA_LENGTH);
    logic                      h_valid, h_ready, h_we, h_rvalid;
    logic [YW-1:0]             h_addr;
    logic [7:0]                h_wdata, h_rdata;
    logic                      a_valid, a_ready;
    logic [BW-1:0]             a_addr;
    logic [SA_LENGTH-1:0][7:0] a_wdata;
    logic                      f_valid, f_ready, f_rvalid;
    logic [BW-1:0]             f_addr;
    logic [SA_LENGTH-1:0][7:0] f_rdata;
    logic                      ub_en, ub_sync_rst, ub_wren, ub_bwren, ub_brden;
    logic [YW-1:0]             ub_wraddr, ub_rdaddr;
    logic [BW-1:0]             ub_bwraddr, ub_brdaddr;
    logic [7:0]                ub_wrdata, ub_rddata;
    logic [SA_LENGTH-1:0][7:0] ub_bwrdata, ub_brddata;
    modport slave (
        input  h_valid, h_we, h_addr, h_wdata, a_valid, a_addr, a_wdata, f_valid, f_addr,
               ub_rddata, ub_brddata,
        output h_ready, h_rvalid, h_rdata, a_ready, f_ready, f_rvalid, f_rdata,
               ub_en, ub_sync_rst, ub_wren, ub_bwren, ub_brden, ub_wraddr, ub_rdaddr,
               ub_bwraddr, ub_brdaddr, ub_wrdata, ub_bwrdata
    );
    modport master (
        output h_valid, h_we, h_addr, h_wdata, a_valid, a_addr, a_wdata, f_valid, f_addr,
               ub_rddata, ub_brddata,
        input  h_ready, h_rvalid, h_rdata, a_ready, f_ready, f_rvalid, f_rdata,
               ub_en, ub_sync_rst, ub_wren, ub_bwren, ub_brden, ub_wraddr, ub_rdaddr,
               ub_bwraddr, ub_brdaddr, ub_wrdata, ub_bwrdata
    );
endinterface

// File: rtl/ub_wr_arb.sv
// ub_wr_arb: accumulator-first write arbiter; a host write that keeps losing is forced
// through once it has lost STARVE_LIMIT consecutive cycles.
module ub_wr_arb #(
    parameter int BW           = 13,
    parameter int STARVE_LIMIT = 4
) (
    input  logic          CLK,
    input  logic          SYNC_RST_N,
    input  logic          i_a_req,
    input  logic          i_h_req,
    input  logic [BW-1:0] i_a_wb,
    input  logic [BW-1:0] i_h_wb,
    output logic          o_a_gnt,
    output logic          o_h_gnt,
    output logic          o_wr_vld,
    output logic [BW-1:0] o_wr_wb
);
    localparam int SW = $clog2(STARVE_LIMIT + 1);
    logic [SW-1:0] r_starve;
    logic          w_force;
    assign w_force  = r_starve == SW'(STARVE_LIMIT);
    assign o_h_gnt  = SYNC_RST_N & i_h_req & (~i_a_req | w_force);
    assign o_a_gnt  = SYNC_RST_N & i_a_req & ~o_h_gnt;
    assign o_wr_vld = o_a_gnt | o_h_gnt;
    assign o_wr_wb  = o_h_gnt ? i_h_wb : i_a_wb;
    always_ff @(posedge CLK)
        if (!SYNC_RST_N) r_starve <= '0;
        else             r_starve <= (i_h_req & ~o_h_gnt) ? r_starve + 1'b1 : '0;
endmodule

// File: rtl/ub_arbiter.sv
// ub_arbiter: shares the Unified_Buffer write port, routes both read paths and holds reads
// that hit the word written this cycle. UB_ARB_STATS_EN adds grant/hazard counters.
module ub_arbiter
    import ub_pkg::*;
#(
    parameter int SA_LENGTH    = 256,
    parameter int ADDR_WIDTH   = 10,
    parameter int NO_BANKS     = 8,
    parameter int STARVE_LIMIT = 4
) (
    input logic      CLK,
    input logic      SYNC_RST_N,
    ub_arb_if.slave  bus
`ifdef UB_ARB_STATS_EN
    ,
    output logic [31:0] stat_a_wr,
    output logic [31:0] stat_h_wr,
    output logic [31:0] stat_hazard
`endif
);
    localparam int BW = bw_f(ADDR_WIDTH, NO_BANKS);
    localparam int LB = $clog2(SA_LENGTH);
    logic          w_a_gnt, w_h_gnt, w_wr_vld, w_h_hz, w_f_hz, w_h_rd, w_f_rd;
    logic [BW-1:0] w_h_wb, w_wr_wb;
    logic          r_h_rvalid, r_f_rvalid;
    assign w_h_wb = bus.h_addr[BW+LB-1:LB];
    ub_wr_arb #(.BW(BW), .STARVE_LIMIT(STARVE_LIMIT)) u_wr_arb (
        .CLK(CLK), .SYNC_RST_N(SYNC_RST_N),
        .i_a_req(bus.a_valid), .i_h_req(bus.h_valid & bus.h_we),
        .i_a_wb(bus.a_addr), .i_h_wb(w_h_wb),
        .o_a_gnt(w_a_gnt), .o_h_gnt(w_h_gnt), .o_wr_vld(w_wr_vld), .o_wr_wb(w_wr_wb)
    );
    // A host byte write blocks reads of its whole word, so compare {word, bank} only
    assign w_h_hz = w_wr_vld & (w_h_wb == w_wr_wb);
    assign w_f_hz = w_wr_vld & (bus.f_addr == w_wr_wb);
    assign w_h_rd = SYNC_RST_N & bus.h_valid & ~bus.h_we & ~w_h_hz;
    assign w_f_rd = SYNC_RST_N & bus.f_valid & ~w_f_hz;
    assign bus.h_ready    = bus.h_we ? w_h_gnt : (SYNC_RST_N & ~w_h_hz);
    assign bus.a_ready    = w_a_gnt;
    assign bus.f_ready    = SYNC_RST_N & ~w_f_hz;
    assign bus.ub_en      = ~SYNC_RST_N | w_wr_vld | w_h_rd | w_f_rd;
    assign bus.ub_sync_rst = ~SYNC_RST_N;
    assign bus.ub_wren    = w_h_gnt;
    assign bus.ub_bwren   = w_a_gnt;
    assign bus.ub_brden   = w_f_rd;
    assign bus.ub_wraddr  = bus.h_addr;
    assign bus.ub_rdaddr  = bus.h_addr;
    assign bus.ub_wrdata  = bus.h_wdata;
    assign bus.ub_bwraddr = bus.a_addr;
    assign bus.ub_bwrdata = bus.a_wdata;
    assign bus.ub_brdaddr = bus.f_addr;
    // Responses in flight are dropped the moment reset asserts
    assign bus.h_rvalid   = r_h_rvalid & SYNC_RST_N;
    assign bus.f_rvalid   = r_f_rvalid & SYNC_RST_N;
    assign bus.h_rdata    = bus.ub_rddata;
    assign bus.f_rdata    = bus.ub_brddata;
    always_ff @(posedge CLK)
        if (!SYNC_RST_N) begin
            r_h_rvalid <= 1'b0;
            r_f_rvalid <= 1'b0;
        end else begin
            r_h_rvalid <= w_h_rd;
            r_f_rvalid <= w_f_rd;
        end
`ifdef UB_ARB_STATS_EN
    logic w_hz_cyc;
    assign w_hz_cyc = SYNC_RST_N & ((bus.h_valid & ~bus.h_we & w_h_hz) | (bus.f_valid & w_f_hz));
    always_ff @(posedge CLK)
        if (!SYNC_RST_N) begin
            stat_a_wr   <= '0;
            stat_h_wr   <= '0;
            stat_hazard <= '0;
        end else begin
            stat_a_wr   <= stat_a_wr + 32'(w_a_gnt & ~&stat_a_wr);
            stat_h_wr   <= stat_h_wr + 32'(w_h_gnt & ~&stat_h_wr);
            stat_hazard <= stat_hazard + 32'(w_hz_cyc & ~&stat_hazard);
        end
`endif
endmodule

// File: tb/tb_ub_arbiter.sv
// tb_ub_arbiter: vector table plus starvation and reset-mid-read sequences; a buffer model
// answers reads and a scoreboard checks every response against a reference memory.
module tb_ub_arbiter;
    import ub_pkg::*;
    localparam int SA = 256, AW = 10, NB = 8, SL = 4;
    localparam int BW = bw_f(AW, NB), YW = yw_f(AW, NB, SA);
    typedef struct {
        logic hv, hw; logic [YW-1:0] ha; logic [7:0] hd;
        logic av; logic [BW-1:0] aa; logic [7:0] sd;
        logic fv; logic [BW-1:0] fa;
        logic ehr, ear, efr, een;
    } vec_t;
    logic clk = 1'b0, rst_n = 1'b0;
    int checks = 0, errors = 0, row = 0, exp_aw = 0, exp_hw = 0, exp_hz = 0;
    ub_word_t bmem [2**BW];
    ub_word_t rmem [2**BW];
    logic [7:0] hq [$];
    ub_word_t   fq [$];
    vec_t rows [15];
`ifdef UB_ARB_STATS_EN
    logic [31:0] stat_a_wr, stat_h_wr, stat_hazard;
`endif
    always #5 clk = ~clk;
    ub_arb_if #(.SA_LENGTH(SA), .ADDR_WIDTH(AW), .NO_BANKS(NB)) bus();
    ub_arbiter #(.SA_LENGTH(SA), .ADDR_WIDTH(AW), .NO_BANKS(NB), .STARVE_LIMIT(SL)) dut (
        .CLK(clk), .SYNC_RST_N(rst_n), .bus(bus)
`ifdef UB_ARB_STATS_EN
        , .stat_a_wr(stat_a_wr), .stat_h_wr(stat_h_wr), .stat_hazard(stat_hazard)
`endif
    );
    // Unified_Buffer stand-in: registered reads, held while ub_en is low, cleared by reset
    always @(posedge clk)
        if (bus.ub_sync_rst) begin
            bus.ub_rddata  <= '0;
            bus.ub_brddata <= '0;
        end else if (bus.ub_en) begin
            bus.ub_rddata <= bmem[bulk_of(int'(bus.ub_rdaddr), SA)][byte_of(int'(bus.ub_rdaddr), SA)];
            if (bus.ub_brden) bus.ub_brddata <= bmem[int'(bus.ub_brdaddr)];
            if (bus.ub_bwren) bmem[int'(bus.ub_bwraddr)] <= bus.ub_bwrdata;
            if (bus.ub_wren)
                bmem[bulk_of(int'(bus.ub_wraddr), SA)][byte_of(int'(bus.ub_wraddr), SA)] <= bus.ub_wrdata;
        end
    function automatic ub_word_t mkword(input int s);
        ub_word_t w;
        for (int i = 0; i < SA; i++) w[i] = 8'(s + i);
        return w;
    endfunction
    function automatic vec_t mkv(input int hv, hw, ha, hd, av, aa, sd, fv, fa, ehr, ear, efr, een);
        vec_t r;
        r.hv = hv[0]; r.hw = hw[0]; r.ha = YW'(ha); r.hd = 8'(hd);
        r.av = av[0]; r.aa = BW'(aa); r.sd = 8'(sd);
        r.fv = fv[0]; r.fa = BW'(fa);
        r.ehr = ehr[0]; r.ear = ear[0]; r.efr = efr[0]; r.een = een[0];
        return r;
    endfunction
    task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got %0h, expected %0h", n, row, got, exp);
        end
    endtask
    task automatic chk_word(input string n, input ub_word_t got, input ub_word_t exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s (row %0d): got low bytes %h, expected %h", n, row, got[3:0], exp[3:0]);
        end
    endtask
    task automatic drain();
        logic [7:0] hb;
        ub_word_t   fw;
        chk("h_rvalid", 32'(bus.h_rvalid), 32'(hq.size() != 0));
        chk("f_rvalid", 32'(bus.f_rvalid), 32'(fq.size() != 0));
        if (hq.size() != 0) begin
            hb = hq.pop_front();
            if (bus.h_rvalid) chk("h_rdata", 32'(bus.h_rdata), 32'(hb));
        end
        if (fq.size() != 0) begin
            fw = fq.pop_front();
            if (bus.f_rvalid) chk_word("f_rdata", bus.f_rdata, fw);
        end
    endtask
    task automatic step(input vec_t v);
        ub_word_t w;
        int k, b;
        bus.h_valid = v.hv; bus.h_we = v.hw; bus.h_addr = v.ha; bus.h_wdata = v.hd;
        bus.a_valid = v.av; bus.a_addr = v.aa; bus.a_wdata = mkword(int'(v.sd));
        bus.f_valid = v.fv; bus.f_addr = v.fa;
        #1;
        if (v.hv) chk("h_ready", 32'(bus.h_ready), 32'(v.ehr));
        if (v.av) chk("a_ready", 32'(bus.a_ready), 32'(v.ear));
        if (v.fv) chk("f_ready", 32'(bus.f_ready), 32'(v.efr));
        chk("ub_en", 32'(bus.ub_en), 32'(v.een));
        chk("ub_wren", 32'(bus.ub_wren), 32'(v.hv & v.hw & v.ehr));
        chk("ub_bwren", 32'(bus.ub_bwren), 32'(v.av & v.ear));
        chk("ub_brden", 32'(bus.ub_brden), 32'(v.fv & v.efr));
        k = bulk_of(int'(v.ha), SA);
        b = byte_of(int'(v.ha), SA);
        w = rmem[k];
        if (v.hv && !v.hw && v.ehr) hq.push_back(w[b]);
        if (v.fv && v.efr) fq.push_back(rmem[int'(v.fa)]);
        if (v.hv && v.hw && v.ehr) begin
            w[b] = v.hd;
            rmem[k] = w;
            exp_hw++;
        end
        if (v.av && v.ear) begin
            rmem[int'(v.aa)] = mkword(int'(v.sd));
            exp_aw++;
        end
        if ((v.hv && !v.hw && !v.ehr) || (v.fv && !v.efr)) exp_hz++;
        @(posedge clk);
        #1;
        drain();
        @(negedge clk);
        row++;
    endtask
    initial begin
        bus.h_valid = 1'b1; bus.h_we = 1'b0; bus.h_addr = '0; bus.h_wdata = '0;
        bus.a_valid = 1'b1; bus.a_addr = '0; bus.a_wdata = '0;
        bus.f_valid = 1'b1; bus.f_addr = '0;
        for (int i = 0; i < 2**BW; i++) rmem[i] = '0;
        //           hv hw ha        hd     av aa     sd     fv fa     ehr ear efr en
        rows[0]  = mkv(0, 0, 0,        0,     1, 'h005, 'h10,  0, 0,     0, 1, 0, 1);
        rows[1]  = mkv(0, 0, 0,        0,     1, 'h007, 'h40,  0, 0,     0, 1, 0, 1);
        rows[2]  = mkv(1, 1, 'h01203, 'hAB,  0, 0,     0,     0, 0,     1, 0, 0, 1);
        rows[3]  = mkv(0, 0, 0,        0,     0, 0,     0,     1, 'h005, 0, 0, 1, 1);
        rows[4]  = mkv(0, 0, 0,        0,     1, 'h012, 'h20,  1, 'h012, 0, 1, 0, 1);
        rows[5]  = mkv(0, 0, 0,        0,     0, 0,     0,     1, 'h012, 0, 0, 1, 1);
        rows[6]  = mkv(1, 0, 'h007F3, 0,     1, 'h009, 'h30,  0, 0,     1, 1, 0, 1);
        rows[7]  = mkv(1, 0, 'h01203, 0,     1, 'h012, 'h50,  0, 0,     0, 1, 0, 1);
        rows[8]  = mkv(1, 0, 'h01203, 0,     0, 0,     0,     0, 0,     1, 0, 0, 1);
        rows[9]  = mkv(1, 1, 'h0050A, 'h77,  0, 0,     0,     1, 'h005, 1, 0, 0, 1);
        rows[10] = mkv(0, 0, 0,        0,     0, 0,     0,     1, 'h005, 0, 0, 1, 1);
        rows[11] = mkv(0, 0, 0,        0,     0, 0,     0,     0, 0,     0, 0, 0, 0);
        rows[12] = mkv(1, 0, 'h00900, 0,     1, 'h001, 'h60,  1, 'h007, 1, 1, 1, 1);
        rows[13] = mkv(1, 1, 'h00102, 'h11,  1, 'h002, 'h61,  0, 0,     0, 1, 0, 1);
        rows[14] = mkv(1, 1, 'h00102, 'h11,  0, 0,     0,     0, 0,     1, 0, 0, 1);
        repeat (3) @(negedge clk);
        #1;
        chk("rst h_ready", 32'(bus.h_ready), 0);
        chk("rst a_ready", 32'(bus.a_ready), 0);
        chk("rst f_ready", 32'(bus.f_ready), 0);
        chk("rst ub_en", 32'(bus.ub_en), 1);
        chk("rst ub_sync_rst", 32'(bus.ub_sync_rst), 1);
        chk("rst wr enables", 32'({bus.ub_wren, bus.ub_bwren, bus.ub_brden}), 0);
        chk("rst rvalids", 32'({bus.h_rvalid, bus.f_rvalid}), 0);
        chk("rst h_rdata", 32'(bus.h_rdata), 0);
`ifdef UB_ARB_STATS_EN
        chk("rst stats", stat_a_wr | stat_h_wr | stat_hazard, 0);
`endif
        rst_n = 1'b1;
        foreach (rows[i]) step(rows[i]);
        // Host write pending against continuous accumulator traffic
        for (int i = 0; i <= SL + 1; i++)
            step(mkv(1, 1, ('h031 << 8) | i, i, 1, 'h030, 'h70 + i, 0, 0,
                     int'(i == SL), int'(i != SL), 0, 1));
`ifdef UB_ARB_STATS_EN
        chk("stat_a_wr", stat_a_wr, 32'(exp_aw));
        chk("stat_h_wr", stat_h_wr, 32'(exp_hw));
        chk("stat_hazard", stat_hazard, 32'(exp_hz));
`endif
        // Reset arriving while a feeder response is in flight
        row = 100;
        bus.h_valid = 1'b0; bus.a_valid = 1'b0; bus.f_valid = 1'b1; bus.f_addr = BW'('h005);
        #1;
        chk("mid f_ready", 32'(bus.f_ready), 1);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0; bus.h_valid = 1'b1; bus.a_valid = 1'b1;
        #1;
        chk("mid f_rvalid", 32'(bus.f_rvalid), 0);
        chk("mid readies", 32'({bus.h_ready, bus.a_ready, bus.f_ready}), 0);
        chk("mid ub_en", 32'(bus.ub_en), 1);
        @(posedge clk);
        #1;
        chk("mid f_rvalid after", 32'(bus.f_rvalid), 0);
        @(negedge clk);
        rst_n = 1'b1;
        step(mkv(0, 0, 0, 0, 0, 0, 0, 1, 'h005, 0, 0, 1, 1));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/ub_arbiter.md
# ub_arbiter

Port arbiter and sequencer in front of `Unified_Buffer`. It shares the buffer's single write path between the accumulator writeback engine (bulk word writes) and the host/DMA byte port, and routes host byte reads and systolic-array feeder bulk reads to the buffer's two read paths. It stalls any read that targets a word being written in the same cycle, so every read sees all previously accepted writes. It also returns read data to requesters with a fixed one-cycle latency.

## Interface
- `SA_LENGTH`, 256: bytes per buffer word; must match the buffer instance.
- `ADDR_WIDTH`, 10: word-address bits per bank.
- `NO_BANKS`, 8: number of banks.
- `STARVE_LIMIT`, 4: maximum number of consecutive cycles a pending host write may lose to the accumulator before it is forced through; must be ≥1.
- Derived widths: BW = ADDR_WIDTH+$clog2(NO_BANKS) is the bulk address width, {word, bank}. YW = BW+$clog2(SA_LENGTH) is the byte address width, {word, bank, byte}.
- `CLK` in 1: the single clock.
- `SYNC_RST_N` in 1: synchronous, active-low reset.
- `h_valid` in 1, `h_ready` out 1: host request handshake.
- `h_we` in 1: 1 = byte write, 0 = byte read.
- `h_addr` in YW, `h_wdata` in 8: host byte address and write data.
- `h_rvalid` out 1, `h_rdata` out 8: host read response.
- `a_valid` in 1, `a_ready` out 1: accumulator bulk write handshake.
- `a_addr` in BW: bulk write address.
- `a_wdata` in 8×[SA_LENGTH]: bulk write data.
- `f_valid` in 1, `f_ready` out 1: feeder bulk read handshake.
- `f_addr` in BW: bulk read address.
- `f_rvalid` out 1, `f_rdata` out 8×[SA_LENGTH]: feeder read response.
- Buffer-side outputs: `ub_en`, `ub_sync_rst`, `ub_wren`, `ub_bwren`, `ub_wraddr`[YW], `ub_bwraddr`[BW], `ub_wrdata`[8], `ub_bwrdata`[8×SA_LENGTH], `ub_brden`, `ub_rdaddr`[YW], `ub_brdaddr`[BW].
- Buffer-side inputs: `ub_rddata` in 8, `ub_brddata` in 8×[SA_LENGTH].

## Operation
- A transfer is accepted in any cycle where both `valid` and `ready` are high. `ready` may depend combinationally on `valid` and the address inputs; `valid` must not depend on `ready`.
- **Write-path arbitration.** Candidates are `a_valid`, and `h_valid` with `h_we=1`.
  - The accumulator has priority by default.
  - A starvation counter `starve` (width $clog2(STARVE_LIMIT+1)) increments on every cycle a host write is pending but not granted.
  - When `starve`==STARVE_LIMIT, the host wins that cycle.
  - `starve` clears on a host write grant, or on any cycle with no pending host write.
  - At most one write is issued per cycle. A host write drives `ub_wren`; an accumulator write drives `ub_bwren`. The two are never asserted together.
- **Read paths.**
  - A host read (`h_we=0`) uses `ub_rdaddr`. A feeder read uses `ub_brdaddr` with `ub_brden`.
  - Both read paths may be issued in the same cycle as each other and as a write.
- **Hazard rule.** If a read's {bank, word} equals the {bank, word} of the write issued in the same cycle, that read is held: its `ready` is low for that cycle. A host byte write hazards against the entire word it targets.
- `ub_en` is high on any cycle that issues a command and on every reset cycle. It is low otherwise, which holds the buffer's read registers.
- `ub_sync_rst` = ~`SYNC_RST_N`.
- Addresses and data pass through to the buffer unmodified.

## Timing
- Commands reach the buffer in the same cycle they are accepted.
- Read latency is 1 cycle:
  - `h_rvalid` pulses in the cycle after a host read is accepted, with `h_rdata`=`ub_rddata`.
  - `f_rvalid` pulses in the cycle after a feeder read is accepted, with `f_rdata`=`ub_brddata`.
- Responses have no backpressure; requesters must sink them.
- Back-to-back reads are accepted one per cycle per path.
- Reset values: all `ready` and `rvalid` outputs are 0. `h_rdata` and `f_rdata` follow the buffer, which clears them. All `ub_*` enables are 0 except `ub_en`=1 and `ub_sync_rst`=1. `starve` is 0.
- A reset asserted while a read response is in flight drops that response: no `rvalid` is issued after reset.
- A read accepted in cycle N returns data that includes every write accepted in cycles before N.

## Configuration
- `UB_ARB_STATS_EN` defined: adds three 32-bit saturating counters, exposed as outputs `stat_a_wr`, `stat_h_wr` and `stat_hazard`.
  - `stat_a_wr` and `stat_h_wr` count write grants.
  - `stat_hazard` counts cycles in which at least one read was held by the hazard rule.
  - All three clear on reset.
- `UB_ARB_STATS_EN` undefined: the ports and counters are absent. Behaviour is otherwise identical.

## Structure
- Shared package `ub_pkg`: the BW/YW width functions, the field-slice helpers (word, bank, byte), and the `ub_word_t` byte-array typedef.
- One sub-module: `ub_wr_arb`, the two-way priority arbiter with its starvation counter. It outputs the grant and the write {bank, word} used for hazard comparison.

## Test plan
- **Feeder read.** Reset, then feeder read at addr 0x005 → `f_rvalid` exactly 1 cycle later, with the data previously written there.
- **Starvation.** Hold `a_valid` continuously and `h_valid`/`h_we=1` with STARVE_LIMIT=4 → the host is granted on its 5th pending cycle, then the accumulator resumes.
- **Same-word hazard.** In the same cycle, accumulator write at word 0x12 and feeder read at 0x12 → `f_ready` is 0 that cycle; the read issues the next cycle and returns the new data.
- **Parallel paths.** Host read at 0x7F3 with an accumulator write to a different word → both accepted in the same cycle; `h_rvalid` arrives the next cycle.
- **Reset mid-read.** Reset asserted the cycle after a feeder read is accepted → no `f_rvalid`; all `ready` outputs are 0 during reset.
- **Stats.** With `UB_ARB_STATS_EN` defined, 3 host writes and 2 hazard cycles → `stat_h_wr`=3 and `stat_hazard`=2.
